// File: rtl/uart_rx_os.sv
// ---------------------------------------------------------------------------
// uart_rx_os -- oversampling UART receiver
//
// Synchronises the asynchronous rx line, oversamples each bit with a 3-sample
// majority vote and deframes DATA_BITS data bits with optional even/odd parity
// and one or two stop bits. Completed words are presented on a valid/ready
// output register together with parity/framing flags.
//
// Optional feature: define UART_RX_BREAK_DET_EN to enable break detection
// (all-zero frame -> o_break pulse instead of a word, then wait for one full
// bit time of idle-high before re-arming the start detector). Without the
// macro o_break is tied low and an all-zero frame is delivered as data 0
// with a framing error.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9)
//   OVERSAMPLE  ticks per bit (even, >= 8)
//   DIV_W       width of the baud divisor
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   i_rx                asynchronous serial line (idles high)
//   i_baud_divisor      clk cycles per oversample tick (0 behaves as 1)
//   i_parity_type       00/11 none, 01 even, 10 odd
//   i_two_stop          1 = two stop bits
//   o_data / o_valid    received word and its valid flag
//   i_ready             consumer accepts the word
//   o_parity_error      parity mismatch on the held word
//   o_framing_error     a stop bit was sampled low on the held word
//   o_overrun_error     1-clk pulse: completed frame dropped
//   o_break             1-clk pulse: break detected
//   o_busy              FSM is outside IDLE
// ---------------------------------------------------------------------------
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    input  logic [DIV_W-1:0]     i_baud_divisor,
    input  logic [1:0]           i_parity_type,
    input  logic                 i_two_stop,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_parity_error,
    output logic                 o_framing_error,
    output logic                 o_overrun_error,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [OS_W-1:0]  TICK_S0   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  TICK_S1   = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  TICK_S2   = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0]  TICK_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_STOP2,
        S_DONE
    } state_t;

    state_t                 state_reg;

    logic                   rx_meta_reg;
    logic                   rx_sync_reg;
    logic                   rx_prev_reg;

    logic [DIV_W-1:0]       div_lat_reg;
    logic [1:0]             par_lat_reg;
    logic                   two_lat_reg;

    logic [DIV_W-1:0]       div_cnt_reg;
    logic [OS_W-1:0]        os_cnt_reg;
    logic [BIT_W-1:0]       bit_idx_reg;
    logic                   samp0_reg;
    logic                   samp1_reg;

    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_bit_reg;
    logic                   stop1_reg;
    logic                   stop2_reg;

    logic [DATA_BITS-1:0]   data_reg;
    logic                   valid_reg;
    logic                   perr_reg;
    logic                   ferr_reg;
    logic                   ovr_reg;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_m1;
    logic             tick;
    logic             resolve;
    logic             bit_end;
    logic             vote;
    logic             fall;
    logic             par_en;
    logic             frame_perr;
    logic             frame_ferr;
    logic             xfer;
    logic             deliver;
    logic             start_ok;

    // A divisor of 0 behaves like 1 (tick every clk).
    assign div_m1  = (div_lat_reg == '0) ? '0 : div_lat_reg - DIV_W'(1);
    assign tick    = (div_cnt_reg == div_m1);
    assign resolve = tick && (os_cnt_reg == TICK_S2);
    assign bit_end = tick && (os_cnt_reg == TICK_LAST);

    // Third sample is the live synchronised line at the resolve tick.
    assign vote = (samp0_reg & samp1_reg) | (samp0_reg & rx_sync_reg) |
                  (samp1_reg & rx_sync_reg);

    assign fall   = rx_prev_reg & ~rx_sync_reg;
    assign par_en = (par_lat_reg == 2'b01) || (par_lat_reg == 2'b10);

    // Expected parity bit is XOR of data, inverted for odd parity.
    assign frame_perr = par_en & (par_bit_reg ^ (^shift_reg) ^ par_lat_reg[1]);
    assign frame_ferr = ~stop1_reg | (two_lat_reg & ~stop2_reg);

    assign xfer = valid_reg & i_ready;

`ifdef UART_RX_BREAK_DET_EN
    logic            brk_reg;
    logic            armed_reg;
    logic [OS_W-1:0] wait_cnt_reg;
    logic            frame_is_break;

    assign frame_is_break = (shift_reg == '0) && (!par_en || !par_bit_reg) && !stop1_reg;
    assign deliver        = (state_reg == S_DONE) && !frame_is_break;
    assign start_ok       = fall & armed_reg;
    assign o_break        = brk_reg;
`else
    assign deliver  = (state_reg == S_DONE);
    assign start_ok = fall;
    assign o_break  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequential logic: synchroniser, tick generator, FSM, output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            div_lat_reg  <= '0;
            par_lat_reg  <= 2'b00;
            two_lat_reg  <= 1'b0;
            div_cnt_reg  <= '0;
            os_cnt_reg   <= '0;
            bit_idx_reg  <= '0;
            samp0_reg    <= 1'b1;
            samp1_reg    <= 1'b1;
            shift_reg    <= '0;
            par_bit_reg  <= 1'b0;
            stop1_reg    <= 1'b1;
            stop2_reg    <= 1'b1;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            ovr_reg      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_reg      <= 1'b0;
            armed_reg    <= 1'b1;
            wait_cnt_reg <= '0;
`endif
        end else begin
            rx_meta_reg <= i_rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;

            // Free-running tick and per-bit tick counters; START entry
            // below overrides both so each frame is aligned to its edge.
            if (tick) begin
                div_cnt_reg <= '0;
                os_cnt_reg  <= (os_cnt_reg == TICK_LAST) ? '0 : os_cnt_reg + OS_W'(1);
                if (os_cnt_reg == TICK_S0) begin
                    samp0_reg <= rx_sync_reg;
                end
                if (os_cnt_reg == TICK_S1) begin
                    samp1_reg <= rx_sync_reg;
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end

            case (state_reg)
                S_IDLE: begin
                    if (start_ok) begin
                        state_reg   <= S_START;
                        div_lat_reg <= i_baud_divisor;
                        par_lat_reg <= i_parity_type;
                        two_lat_reg <= i_two_stop;
                        div_cnt_reg <= '0;
                        os_cnt_reg  <= '0;
                        par_bit_reg <= 1'b0;
                    end
                end
                S_START: begin
                    if (resolve && vote) begin
                        state_reg <= S_IDLE;        // false start
                    end else if (bit_end) begin
                        state_reg   <= S_DATA;
                        bit_idx_reg <= '0;
                    end
                end
                S_DATA: begin
                    if (resolve) begin
                        shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                    end
                    if (bit_end) begin
                        if (bit_idx_reg == BIT_LAST) begin
                            state_reg <= par_en ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + BIT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (resolve) begin
                        par_bit_reg <= vote;
                    end
                    if (bit_end) begin
                        state_reg <= S_STOP;
                    end
                end
                S_STOP: begin
                    // A single stop bit ends the frame at its mid-bit so the
                    // next start edge can be accepted right after.
                    if (resolve) begin
                        stop1_reg <= vote;
                        if (!two_lat_reg) begin
                            state_reg <= S_DONE;
                        end
                    end
                    if (bit_end) begin
                        state_reg <= S_STOP2;
                    end
                end
                S_STOP2: begin
                    if (resolve) begin
                        stop2_reg <= vote;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase

            // Output register / handshake
            ovr_reg <= 1'b0;
            if (deliver && (!valid_reg || xfer)) begin
                data_reg  <= shift_reg;
                perr_reg  <= frame_perr;
                ferr_reg  <= frame_ferr;
                valid_reg <= 1'b1;
            end else if (deliver) begin
                ovr_reg <= 1'b1;
            end else if (xfer) begin
                valid_reg <= 1'b0;
                perr_reg  <= 1'b0;
                ferr_reg  <= 1'b0;
            end

`ifdef UART_RX_BREAK_DET_EN
            brk_reg <= 1'b0;
            if (state_reg == S_DONE && frame_is_break) begin
                brk_reg      <= 1'b1;
                armed_reg    <= 1'b0;
                wait_cnt_reg <= '0;
            end else if (!armed_reg) begin
                // Re-arm only after one unbroken bit time of idle-high.
                if (!rx_sync_reg) begin
                    wait_cnt_reg <= '0;
                end else if (tick) begin
                    if (wait_cnt_reg == TICK_LAST) begin
                        armed_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + OS_W'(1);
                    end
                end
            end
`endif
        end
    end

    assign o_data          = data_reg;
    assign o_valid         = valid_reg;
    assign o_parity_error  = perr_reg;
    assign o_framing_error = ferr_reg;
    assign o_overrun_error = ovr_reg;
    assign o_busy          = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_os -- self-checking bench for uart_rx_os
//
// Two instances: an 8-bit receiver for most cases and a 9-bit receiver for
// the wide-frame case. Frames are built bit-by-bit from the line protocol
// (start, data LSB-first, optional parity, stop bits) and expected words are
// derived from that same protocol description, not from receiver internals.
// ---------------------------------------------------------------------------
module tb_uart_rx_os;

    localparam int OS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx8, rx9, rdy8, rdy9;
    logic [15:0] div;
    logic [1:0]  ptype;
    logic        two;

    logic [7:0]  data8;
    logic        v8, pe8, fe8, ov8, bk8, busy8;
    logic [8:0]  data9;
    logic        v9, pe9, fe9, ov9, bk9, busy9;

    always #5 clk = ~clk;

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(OS), .DIV_W(16)) dut8 (
        .clk(clk), .rst(rst), .i_rx(rx8), .i_baud_divisor(div),
        .i_parity_type(ptype), .i_two_stop(two), .o_data(data8),
        .o_valid(v8), .i_ready(rdy8), .o_parity_error(pe8),
        .o_framing_error(fe8), .o_overrun_error(ov8), .o_break(bk8),
        .o_busy(busy8)
    );

    uart_rx_os #(.DATA_BITS(9), .OVERSAMPLE(OS), .DIV_W(16)) dut9 (
        .clk(clk), .rst(rst), .i_rx(rx9), .i_baud_divisor(div),
        .i_parity_type(ptype), .i_two_stop(two), .o_data(data9),
        .o_valid(v9), .i_ready(rdy9), .o_parity_error(pe9),
        .o_framing_error(fe9), .o_overrun_error(ov9), .o_break(bk9),
        .o_busy(busy9)
    );

    int errors = 0;
    int checks = 0;

    // Monitor: every accepted word is logged as {perr, ferr, data[8:0]}.
    logic [10:0] obs8[$];
    logic [10:0] obs9[$];
    int          ovr_cnt8 = 0;
    int          brk_cnt8 = 0;
    int          rd8 = 0;
    int          rd9 = 0;

    always @(negedge clk) begin
        if (v8 && rdy8) obs8.push_back({pe8, fe8, 1'b0, data8});
        if (v9 && rdy9) obs9.push_back({pe9, fe9, data9});
        if (ov8) ovr_cnt8 = ovr_cnt8 + 1;
        if (bk8) brk_cnt8 = brk_cnt8 + 1;
    end

    initial begin
        #(10 * 300000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", nm, act);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int bit_time(input int dv);
        return ((dv == 0) ? 1 : dv) * OS;
    endfunction

    task automatic drive_line(input int which, input logic val);
        if (which == 0) rx8 = val;
        else            rx9 = val;
    endtask

    task automatic send_frame(input int which, input int nbits, input logic [8:0] d,
                              input logic [1:0] pt, input logic pbit, input logic ts,
                              input logic s1, input logic s2, input int dv);
        logic q[$];
        div   = 16'(dv);
        ptype = pt;
        two   = ts;
        q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) q.push_back(d[i]);
        if (pt == 2'b01 || pt == 2'b10) q.push_back(pbit);
        q.push_back(s1);
        if (ts) q.push_back(s2);
        foreach (q[i]) begin
            drive_line(which, q[i]);
            wait_clks(bit_time(dv));
        end
        drive_line(which, 1'b1);
        wait_clks(2 * bit_time(dv));
    endtask

    task automatic expect_word8(input string nm, input logic [7:0] ed, input logic ep, input logic ef);
        logic [10:0] w;
        check({nm, " words"}, 32'(obs8.size() - rd8), 32'd1);
        if (obs8.size() > rd8) begin
            w = obs8[rd8];
            check({nm, " data"}, 32'(w[7:0]), 32'(ed));
            check({nm, " perr"}, 32'(w[10]), 32'(ep));
            check({nm, " ferr"}, 32'(w[9]), 32'(ef));
        end
        rd8 = obs8.size();
    endtask

    typedef struct {
        logic [7:0] d;
        logic [1:0] pt;
        logic       pb;
        logic       ts;
        logic       s1;
        logic       s2;
        int         dv;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [7:0] d;
        logic [1:0] pt;
        logic       ts, s1, s2, pb, ep, ef, busy_seen;
        int         dv, base_ovr, base_brk, ones;
        logic [10:0] w;

        //            d      pt     pb    ts    s1    s2    dv   ed     ep    ef
        tbl[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 27, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1,  4, 8'h03, 1'b1, 1'b0};
        tbl[2] = '{8'h80, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1,  4, 8'h80, 1'b0, 1'b0};
        tbl[3] = '{8'h7E, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1,  3, 8'h7E, 1'b0, 1'b0};
        tbl[4] = '{8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1,  4, 8'h3C, 1'b0, 1'b1};
        tbl[5] = '{8'h01, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0,  2, 8'h01, 1'b1, 1'b1};
        tbl[6] = '{8'hFF, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1,  0, 8'hFF, 1'b0, 1'b1};
        tbl[7] = '{8'h00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1,  5, 8'h00, 1'b1, 1'b0};

        rst = 1'b1; rx8 = 1'b1; rx9 = 1'b1; rdy8 = 1'b1; rdy9 = 1'b1;
        div = 16'd4; ptype = 2'b00; two = 1'b0;
        wait_clks(5);

        // Reset state
        check("reset valid",  32'(v8),    32'd0);
        check("reset data",   32'(data8), 32'd0);
        check("reset perr",   32'(pe8),   32'd0);
        check("reset ferr",   32'(fe8),   32'd0);
        check("reset ovr",    32'(ov8),   32'd0);
        check("reset break",  32'(bk8),   32'd0);
        check("reset busy",   32'(busy8), 32'd0);
        rst = 1'b0;
        wait_clks(4);
        check("idle busy", 32'(busy8), 32'd0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            send_frame(0, 8, {1'b0, tbl[i].d}, tbl[i].pt, tbl[i].pb, tbl[i].ts,
                       tbl[i].s1, tbl[i].s2, tbl[i].dv);
            expect_word8($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ep, tbl[i].ef);
        end

        // False start: 5-tick glitch at divisor 4
        div = 16'd4;
        busy_seen = 1'b0;
        rx8 = 1'b0;
        for (int i = 0; i < bit_time(4); i++) begin
            if (i == 5 * 4) rx8 = 1'b1;
            wait_clks(1);
            if (busy8) busy_seen = 1'b1;
        end
        check("false start busy seen", 32'(busy_seen), 32'd1);
        check("false start busy back", 32'(busy8), 32'd0);
        wait_clks(2 * bit_time(4));
        check("false start no word", 32'(obs8.size() - rd8), 32'd0);
        rd8 = obs8.size();

        // Overrun: two frames with i_ready low
        rdy8 = 1'b0;
        base_ovr = ovr_cnt8;
        send_frame(0, 8, 9'h011, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        send_frame(0, 8, 9'h022, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        check("overrun valid held", 32'(v8), 32'd1);
        check("overrun data held", 32'(data8), 32'h11);
        check("overrun pulses", 32'(ovr_cnt8 - base_ovr), 32'd1);
        rdy8 = 1'b1;
        wait_clks(2);
        expect_word8("overrun drain", 8'h11, 1'b0, 1'b0);
        check("overrun valid cleared", 32'(v8), 32'd0);

        // Wide frame on the 9-bit receiver, second stop bit low
        send_frame(1, 9, 9'h1FF, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 4);
        check("wide words", 32'(obs9.size() - rd9), 32'd1);
        if (obs9.size() > rd9) begin
            w = obs9[rd9];
            check("wide data", 32'(w[8:0]), 32'h1FF);
            check("wide perr", 32'(w[10]), 32'd0);
            check("wide ferr", 32'(w[9]), 32'd1);
        end
        rd9 = obs9.size();

        // Reset in the middle of a frame
        div = 16'd4;
        rx8 = 1'b0;
        wait_clks(3 * bit_time(4));
        check("midframe busy", 32'(busy8), 32'd1);
        rst = 1'b1;
        wait_clks(2);
        check("midreset busy", 32'(busy8), 32'd0);
        rx8 = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(12 * bit_time(4));
        check("midreset no word", 32'(obs8.size() - rd8), 32'd0);
        check("midreset busy after", 32'(busy8), 32'd0);
        rd8 = obs8.size();

        // Break: line low for 12 bit times
        div = 16'd4; ptype = 2'b00; two = 1'b0;
        base_brk = brk_cnt8;
        rx8 = 1'b0;
        wait_clks(12 * bit_time(4));
        rx8 = 1'b1;
        wait_clks(2 * bit_time(4));
`ifdef UART_RX_BREAK_DET_EN
        check("break pulses", 32'(brk_cnt8 - base_brk), 32'd1);
        check("break no word", 32'(obs8.size() - rd8), 32'd0);
        check("break valid", 32'(v8), 32'd0);
        rd8 = obs8.size();
`else
        check("break pulses", 32'(brk_cnt8 - base_brk), 32'd0);
        expect_word8("break word", 8'h00, 1'b0, 1'b1);
`endif
        send_frame(0, 8, 9'h05A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        expect_word8("after break", 8'h5A, 1'b0, 1'b0);

        // Randomised frames against the protocol-level model
        for (int n = 0; n < 16; n++) begin
            d  = 8'($urandom_range(0, 255));
            pt = 2'($urandom_range(0, 3));
            ts = 1'($urandom_range(0, 1));
            pb = 1'($urandom_range(0, 1));
            dv = $urandom_range(0, 5);
            s1 = ($urandom_range(0, 7) != 0);
            s2 = ($urandom_range(0, 7) != 0);
            if (d == 8'h00 && !s1) s1 = 1'b1;   // keep clear of the break pattern
            ones = $countones(d) + int'(pb);
            if (pt == 2'b01)      ep = (ones % 2) != 0;   // even: total ones even
            else if (pt == 2'b10) ep = (ones % 2) == 0;   // odd: total ones odd
            else                  ep = 1'b0;
            ef = !s1 || (ts && !s2);
            send_frame(0, 8, {1'b0, d}, pt, pb, ts, s1, s2, dv);
            expect_word8($sformatf("rand%0d", n), d, ep, ef);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver, the successor to the fixed 8-bit receiver in `UART_top`. It synchronises the serial line, oversamples each bit with 3-sample majority voting, and deframes 5–9 data bits with runtime-selectable parity and 1 or 2 stop bits. It presents each received word on a valid/ready output port, with per-word parity and framing flags and an overrun indication. It sits between the pad-side `rx` line and the RX FIFO write port.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `OVERSAMPLE`, 16: oversample ticks per bit; even, at least 8.
- `DIV_W`, 16: width of the baud divisor.

- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous and active-high.
- `i_rx` in 1: asynchronous serial line; idles high.
- `i_baud_divisor` in DIV_W: clk cycles per oversample tick; 0 is treated as 1.
- `i_parity_type` in 2: 00 none, 01 even, 10 odd, 11 none.
- `i_two_stop` in 1: 1 selects two stop bits.
- `o_data` out DATA_BITS: received word, LSB = first bit on the line.
- `o_valid` out 1: `o_data` and its flags are valid.
- `i_ready` in 1: consumer accepts the word.
- `o_parity_error` out 1: parity mismatch on the word held in `o_data`.
- `o_framing_error` out 1: a stop bit was sampled low on the word held in `o_data`.
- `o_overrun_error` out 1: one-cycle pulse when a completed frame was dropped.
- `o_break` out 1: one-cycle pulse on break detection.
- `o_busy` out 1: high in every state except IDLE.

## Operation
- Input path: 2-flop synchroniser on `i_rx`, then a third register used for falling-edge detection.
- Tick generator:
  - Counter runs 0..divisor-1 and issues a one-clk tick at terminal count.
  - The counter restarts at 0 on entry to START, so each frame is phase-aligned to its start edge.
- Bit sampling:
  - A per-bit tick counter runs 0..OVERSAMPLE-1.
  - Samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the majority of the three samples and is resolved at tick OVERSAMPLE/2+1.
- `i_baud_divisor`, `i_parity_type` and `i_two_stop` are latched on entry to START. Changes mid-frame take effect on the next frame.
- FSM:
  - IDLE: waits for a synchronised falling edge, then goes to START.
  - START: if the majority-voted start bit is 1, it is a false start; return to IDLE with no output. Otherwise go to DATA.
  - DATA: shifts in DATA_BITS bits LSB-first. Goes to PARITY if parity is enabled, else to STOP.
  - PARITY: compares the received bit with the computed parity. Even parity means the XOR of the data and parity bits is 0; odd parity means it is 1.
  - STOP: samples the first stop bit. Goes to STOP2 if `i_two_stop` is set, else to DONE.
  - STOP2: samples the second stop bit, then goes to DONE.
  - DONE: lasts one clk, loads the output register and returns to IDLE.
- The frame completes at the mid-bit of the last stop bit. The next start edge is accepted immediately after that point.
- Framing error is flagged if any stop-bit sample is 0.
- Output register and handshake:
  - A transfer occurs on a clk where `o_valid` and `i_ready` are both 1.
  - DONE with `o_valid`=0, or with a transfer in the same clk: load `o_data` and both error flags, and set `o_valid`=1.
  - DONE with `o_valid`=1 and `i_ready`=0: keep the old word and flags, and pulse `o_overrun_error`.
  - A transfer with no DONE in the same clk clears `o_valid`. The flags are don't-care while `o_valid`=0 and are driven 0.
- Reset, including mid-frame: the partial frame is discarded and the FSM returns to IDLE. All outputs go to 0 except `o_data`, which also resets to 0.

## Timing
- From the synchronised falling edge to START: 1 clk.
- Raw `i_rx` edge to the synchroniser output: 2–3 clk.
- From the last stop-bit majority-resolve tick to `o_valid`=1: 2 clk (tick → DONE → register).
- `o_overrun_error` and `o_break` pulse for exactly 1 clk, aligned with the cycle the load would have occurred.
- Baud error tolerance is ±3% for OVERSAMPLE=16.

## Configuration
- `UART_RX_BREAK_DET_EN` defined:
  - A frame with all data bits 0, parity bit 0 (if enabled) and the first stop bit 0 is a break.
  - On a break: pulse `o_break`, do not set `o_valid`, report no framing error.
  - The FSM then stays in IDLE-wait until the synchronised line has been high for one full bit time before arming the start detector.
- Not defined:
  - `o_break` is tied to 0.
  - An all-zero frame is delivered as data 0 with `o_framing_error`=1.
  - The normal IDLE falling-edge rule applies.

## Test plan
- Normal frame: divisor 27, 8N1, frame 0xA5, `i_ready`=1 → `o_data`=0xA5 with `o_valid` high for 1 clk, no error flags.
- Parity mismatch: even parity, data 0x03 sent with parity bit 1 → `o_data`=0x03, `o_parity_error`=1, `o_framing_error`=0.
- False start: a 5-tick low glitch on the idle line → `o_busy` returns to 0 within 1 bit time, no `o_valid`.
- Overrun: `i_ready`=0, frames 0x11 then 0x22 → `o_data` stays 0x11, `o_overrun_error` pulses once. Raising `i_ready` then transfers 0x11.
- Wide frame with two stop bits: DATA_BITS=9, `i_two_stop`=1, frame 0x1FF with the second stop bit driven 0 → `o_data`=0x1FF, `o_framing_error`=1.
- Break: line held low for 12 bit times, then high → with the macro, one `o_break` pulse and no `o_valid`. Without it, `o_data`=0 with `o_framing_error`=1.
